// File: rtl/cnn_pkg.sv
// Shared CNN classifier definitions: default sizes, result word field layout,
// and the logit arg-max FSM state type.
package cnn_pkg;

  localparam int unsigned NUM_CLASSES_DEF = 10;
  localparam int unsigned LOGIT_W_DEF     = 16;

  localparam int unsigned RESULT_W      = 32;
  localparam int unsigned RES_DONE_BIT  = 31;
  localparam int unsigned RES_ERR_BIT   = 30;
  localparam int unsigned RES_SEQ_LSB   = 24;
  localparam int unsigned RES_SEQ_W     = 6;
  localparam int unsigned RES_IDX_LSB   = 16;
  localparam int unsigned RES_IDX_W     = 8;
  localparam int unsigned RES_LOGIT_LSB = 0;
  localparam int unsigned RES_LOGIT_W   = 16;

  // Beat counter must hold NUM_CLASSES up to 255.
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_COMMIT = 2'd2
  } argmax_state_t;

  typedef struct packed {
    logic                   done;
    logic                   err;
    logic [RES_SEQ_W-1:0]   seq;
    logic [RES_IDX_W-1:0]   idx;
    logic [RES_LOGIT_W-1:0] logit;
  } argmax_result_t;

endpackage

// File: rtl/logit_argmax_if.sv
// Logit beat stream from the classifier's final layer into logit_argmax.
interface logit_argmax_if #(
  parameter int unsigned LOGIT_W = cnn_pkg::LOGIT_W_DEF
);

  logic               logit_valid;
  logic               logit_ready;
  logic [LOGIT_W-1:0] logit_data;
  logic               logit_last;

  modport master (
    output logit_valid,
    output logit_data,
    output logit_last,
    input  logit_ready
  );

  modport slave (
    input  logit_valid,
    input  logit_data,
    input  logit_last,
    output logit_ready
  );

endinterface

// File: rtl/logit_argmax.sv
// Running arg-max over one frame of signed logits, committed as a 32-bit status word.
// Optional frame sequence counter on result[29:24] when LOGIT_ARGMAX_SEQ_EN is defined.
module logit_argmax
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int unsigned LOGIT_W     = LOGIT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  logit_argmax_if.slave       s,
  input  logic                clear,
  output logic [RESULT_W-1:0] result
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CLASSES);

  argmax_state_t             state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc_c;
  logic signed [LOGIT_W-1:0] max_q, max_d, data_c;
  logic [RES_IDX_W-1:0]      idx_q, idx_d;
  logic                      ferr_q, ferr_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [RES_IDX_W-1:0]      res_idx_q, res_idx_d;
  logic signed [LOGIT_W-1:0] res_max_q, res_max_d;
  logic [RES_SEQ_W-1:0]      seq_c;
  logic                      ready_c, accept_c, hit_n_c;
  argmax_result_t            result_c;

  assign data_c    = s.logit_data;
  // Held low while reset is asserted; otherwise a pure function of state.
  assign ready_c   = reset_n & (state_q != ST_COMMIT);
  assign s.logit_ready = ready_c;
  assign accept_c  = s.logit_valid & ready_c;
  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign hit_n_c   = (cnt_inc_c == LAST_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      res_idx_q <= '0;
      res_max_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      res_idx_q <= res_idx_d;
      res_max_q <= res_max_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    idx_d     = idx_q;
    ferr_d    = ferr_q;
    done_d    = done_q;
    err_d     = err_q;
    res_idx_d = res_idx_q;
    res_max_d = res_max_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          max_d = data_c;
          idx_d = '0;
          cnt_d = CNT_W'(1);
          if (s.logit_last) begin
            state_d = ST_COMMIT;
            ferr_d  = (LAST_CNT != CNT_W'(1));
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (accept_c) begin
          cnt_d = cnt_inc_c;
          // Strictly greater: ties keep the earlier class.
          if (data_c > max_q) begin
            max_d = data_c;
            idx_d = cnt_q;
          end
          if (s.logit_last || hit_n_c) begin
            state_d = ST_COMMIT;
            ferr_d  = !(s.logit_last && hit_n_c);
          end
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // A commit overrides a coincident clear; error stays sticky otherwise.
    if (state_q == ST_COMMIT) begin
      done_d    = 1'b1;
      err_d     = ferr_q | (err_q & ~clear);
      res_idx_d = idx_q;
      res_max_d = max_q;
    end else if (clear) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
  end

`ifdef LOGIT_ARGMAX_SEQ_EN
  logic [RES_SEQ_W-1:0] seq_q, seq_d;

  always_comb begin
    seq_d = seq_q;
    if (state_q == ST_COMMIT) seq_d = seq_q + RES_SEQ_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) seq_q <= '0;
    else          seq_q <= seq_d;
  end

  assign seq_c = seq_q;
`else
  assign seq_c = '0;
`endif

  always_comb begin
    result_c.done  = done_q;
    result_c.err   = err_q;
    result_c.seq   = seq_c;
    result_c.idx   = res_idx_q;
    result_c.logit = RES_LOGIT_W'(res_max_q);
  end

  assign result = result_c;

endmodule

// File: tb/tb_logit_argmax.sv
// Self-checking bench for logit_argmax: directed frame table, clear/reset corners,
// and random frames checked against a frame-level arg-max model.
module tb_logit_argmax;
  import cnn_pkg::*;

  localparam int unsigned N = 10;
  localparam int unsigned W = 16;
  localparam int unsigned NV = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [31:0] result;

  always #5 clk = ~clk;

  logit_argmax_if #(.LOGIT_W(W)) bus ();

  logit_argmax #(.NUM_CLASSES(N), .LOGIT_W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (bus.slave),
    .clear   (clear),
    .result  (result)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]        m_res = 32'h0;
  logic signed [15:0] fb[$];

  typedef struct packed {
    int          len;
    logic        with_last;
    logic        clr_before;
    logic        clr_at_commit;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[NV];
  int   vd[NV][10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] next_seq(input logic [5:0] s);
`ifdef LOGIT_ARGMAX_SEQ_EN
    return s + 6'd1;
`else
    return 6'd0 & s;
`endif
  endfunction

  // Frame-level reference: first index of the maximum, error unless exactly N beats ending in last.
  task automatic model_commit(input bit last_seen, input bit clr);
    logic signed [15:0] mx;
    int                 idx;
    bit                 ferr;
    logic               err;
    mx = fb[0];
    foreach (fb[i]) if (fb[i] > mx) mx = fb[i];
    idx = 0;
    for (int i = fb.size() - 1; i >= 0; i--) if (fb[i] == mx) idx = i;
    ferr  = !(last_seen && fb.size() == N);
    err   = ferr | (m_res[30] & ~clr);
    m_res = {1'b1, err, next_seq(m_res[29:24]), 8'(idx), mx};
    fb.delete();
  endtask

  task automatic send_beat(input logic signed [15:0] d, input bit last, input int unsigned gap);
    int t;
    if (gap > 0) begin
      bus.logit_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.logit_valid = 1'b1;
    bus.logit_data  = d;
    bus.logit_last  = last;
    t = 0;
    while (!bus.logit_ready && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (!bus.logit_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: ready=%b expected 1", bus.logit_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic end_frame_check(input bit last_seen, input bit clr, input string name);
    bus.logit_valid = 1'b0;
    bus.logit_last  = 1'b0;
    check({name, "_ready_bubble"}, 32'(bus.logit_ready), 32'd0);
    clear = clr;
    model_commit(last_seen, clr);
    @(negedge clk);
    clear = 1'b0;
    check({name, "_result"}, result, m_res);
    check({name, "_ready_back"}, 32'(bus.logit_ready), 32'd1);
  endtask

  task automatic play_frame(input logic signed [15:0] d[$], input bit with_last,
                            input int unsigned max_gap, input bit clr, input string name);
    for (int i = 0; i < d.size(); i++) begin
      bit lst;
      lst = with_last && (i == d.size() - 1);
      send_beat(d[i], lst, (max_gap == 0) ? 0 : $urandom_range(max_gap, 0));
      fb.push_back(d[i]);
    end
    end_frame_check(with_last, clr, name);
  endtask

  task automatic pulse_clear(input string name);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_res[31:30] = 2'b00;
    check(name, result, m_res);
  endtask

  task automatic do_reset();
    bus.logit_valid = 1'b0;
    bus.logit_last  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("reset_result", result, 32'h0);
    check("reset_ready", 32'(bus.logit_ready), 32'd0);
    m_res = 32'h0;
    fb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("release_ready", 32'(bus.logit_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] q[$];
    logic [5:0]         seq_exp;

    vd = '{'{-5, 3, 7, 2, 7, -1, 0, 6, 1, -8},
           '{-10, -9, -8, -7, -6, -5, -4, -3, -20, -2},
           '{1, 5, -3, 2, 0, 0, 0, 0, 0, 0},
           '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9},
           '{3, 3, 3, 9, 9, 1, 0, 0, 0, 0},
           '{1, 2, 3, 50, 4, 5, 6, 7, 8, 9},
           '{100, 1, 2, 3, 4, 5, 6, 7, 8, 9},
           '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1}};
    vecs[0] = '{len: 10, with_last: 1, clr_before: 0, clr_at_commit: 0, exp: 32'h8002_0007};
    vecs[1] = '{len: 10, with_last: 1, clr_before: 0, clr_at_commit: 0, exp: 32'h8009_FFFE};
    vecs[2] = '{len: 4,  with_last: 1, clr_before: 0, clr_at_commit: 0, exp: 32'hC001_0005};
    vecs[3] = '{len: 10, with_last: 1, clr_before: 0, clr_at_commit: 0, exp: 32'hC009_0009};
    vecs[4] = '{len: 10, with_last: 1, clr_before: 1, clr_at_commit: 0, exp: 32'h8003_0009};
    vecs[5] = '{len: 10, with_last: 0, clr_before: 0, clr_at_commit: 0, exp: 32'hC003_0032};
    vecs[6] = '{len: 10, with_last: 1, clr_before: 0, clr_at_commit: 0, exp: 32'hC000_0064};
    vecs[7] = '{len: 10, with_last: 1, clr_before: 0, clr_at_commit: 1, exp: 32'h8000_FFFF};

    clear           = 1'b0;
    bus.logit_data  = '0;
    reset_n         = 1'b0;
    bus.logit_valid = 1'b0;
    bus.logit_last  = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // Directed frames, applied in order so sticky error carries between them.
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].clr_before) begin
        pulse_clear($sformatf("vec%0d_clear", i));
        check($sformatf("vec%0d_clear_flags", i), 32'(result[31:30]), 32'd0);
      end
      q.delete();
      for (int j = 0; j < vecs[i].len; j++) q.push_back(16'(vd[i][j]));
      play_frame(q, vecs[i].with_last, 0, vecs[i].clr_at_commit, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_table", i), result & 32'hC0FF_FFFF, vecs[i].exp);
    end

    // Clear after a commit-cycle clear: flags drop, payload bits stay.
    pulse_clear("clear_after_commit");
    check("clear_after_commit_table", result & 32'hC0FF_FFFF, 32'h0000_FFFF);

    // Same frame as vec0 but with random valid gaps.
    q.delete();
    for (int j = 0; j < 10; j++) q.push_back(16'(vd[0][j]));
    play_frame(q, 1'b1, 3, 1'b0, "gap_frame");
    check("gap_frame_table", result & 32'hC0FF_FFFF, 32'h8002_0007);

    // Random frames: good, short and long, with gaps and occasional clears.
    for (int f = 0; f < 40; f++) begin
      int unsigned kind, len;
      bit          wl;
      kind = $urandom_range(3, 0);
      if (kind == 2) begin
        len = $urandom_range(N - 1, 1);
        wl  = 1'b1;
      end else if (kind == 3) begin
        len = N;
        wl  = 1'b0;
      end else begin
        len = N;
        wl  = 1'b1;
      end
      if ($urandom_range(4, 0) == 0) pulse_clear($sformatf("rnd%0d_clear", f));
      q.delete();
      for (int j = 0; j < int'(len); j++) begin
        if ($urandom_range(1, 0) == 0) q.push_back(16'($urandom));
        else                           q.push_back(16'(int'($urandom_range(15, 0)) - 8));
      end
      play_frame(q, wl, 3, ($urandom_range(5, 0) == 0), $sformatf("rnd%0d", f));
    end

    // Reset in the middle of a frame discards it.
    send_beat(16'sd77, 1'b0, 0);
    send_beat(16'sd12, 1'b0, 0);
    send_beat(-16'sd3, 1'b0, 0);
    do_reset();
    q.delete();
    for (int j = 0; j < 10; j++) q.push_back(16'(vd[1][j]));
    play_frame(q, 1'b1, 0, 1'b0, "post_reset");
    check("post_reset_seq", 32'(result[29:24]), 32'(next_seq(6'd0)));

    // 65 frames from a clean reset wrap the sequence counter once.
    do_reset();
    for (int f = 0; f < 65; f++) begin
      q.delete();
      for (int j = 0; j < int'(N); j++) q.push_back(16'($urandom));
      play_frame(q, 1'b1, 0, 1'b0, $sformatf("wrap%0d", f));
    end
`ifdef LOGIT_ARGMAX_SEQ_EN
    seq_exp = 6'd1;
`else
    seq_exp = 6'd0;
`endif
    check("seq_wrap", 32'(result[29:24]), 32'(seq_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logit_argmax.md
# logit_argmax

Collects the per-class logit stream emitted by the CNN classifier's final layer, one signed logit per beat, and tracks the running maximum. At each frame end it commits a 32-bit status/result word holding the winning class index, its logit value, a done flag and an error flag. It sits directly upstream of the HPS logit input PIO: `result` drives that PIO's `in_port`, and software polls it over Avalon.

## Interface
Parameters:
- `NUM_CLASSES`, 10: logits per frame; legal range 2..255.
- `LOGIT_W`, 16: logit width in bits, signed two's complement; legal range 2..16.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `logit_valid`  in  1  beat valid.
- `logit_ready`  out  1  beat accepted when `logit_valid & logit_ready`.
- `logit_data`  in  `LOGIT_W`  signed logit.
- `logit_last`  in  1  final beat of the frame.
- `clear`  in  1  single-cycle pulse from the HPS control PIO; clears done and error.
- `result`  out  32  status word; layout under Operation.

## Operation
- `result` layout:
  - [31] done.
  - [30] error.
  - [29:24] frame sequence; zero unless `LOGIT_ARGMAX_SEQ_EN` is defined.
  - [23:16] class index, zero-extended.
  - [15:0] max logit, sign-extended from `LOGIT_W`.
- FSM states: IDLE, ACCUM, COMMIT.
  - IDLE: `logit_ready`=1. The first accepted beat loads max=data, idx=0, cnt=1 and moves to ACCUM. If that beat also has `logit_last`, go to COMMIT instead.
  - ACCUM: `logit_ready`=1. Each accepted beat does cnt++. If `data > max` (signed, strictly greater), load max=data and idx=cnt. Ties keep the lower index.
  - ACCUM exits to COMMIT when the accepted beat has `logit_last` or makes cnt==NUM_CLASSES.
  - COMMIT: `logit_ready`=0 for exactly one cycle. Write `result` atomically, then go to IDLE.
- Error at commit when either holds:
  - `logit_last` arrives with cnt != NUM_CLASSES (short frame).
  - cnt reaches NUM_CLASSES without `logit_last` (long frame). The frame is force-terminated; the next beat starts a new frame.
- At commit, done is set. Error is set on an error frame; otherwise error is held (sticky until `clear`).
- `result` retains the last committed frame while the next frame accumulates; partial state is never visible.
- `clear`: done←0 and error←0. Index, logit and sequence fields are untouched. If `clear` and a commit occur in the same cycle, the commit wins: done=1, and error reflects that frame only.
- `logit_valid` low mid-frame: state holds indefinitely; there is no timeout.

## Timing
- Reset values: `result`=32'h0, `logit_ready`=0 during reset and 1 in the first cycle after release. Internal state is IDLE with cnt, max and idx at 0.
- Latency: last beat accepted at edge k → `result` updated at edge k+1.
- Throughput: NUM_CLASSES+1 cycles per frame at full rate (one bubble in COMMIT).
- `clear` takes effect at the next edge.
- Reset mid-frame discards the partial frame; `result` returns to 0.
- No combinational path from inputs to `result`. `logit_ready` is a function of state only.

## Configuration
- `LOGIT_ARGMAX_SEQ_EN` defined:
  - A 6-bit frame sequence counter increments on each commit, wrapping 63→0, and is driven on [29:24].
  - Software uses it to detect missed frames.
  - Reset value 0; `clear` does not affect it.
- `LOGIT_ARGMAX_SEQ_EN` not defined: no counter is built and [29:24] is constant 0.

## Structure
- Shared package `cnn_pkg`: `NUM_CLASSES_DEF`, `LOGIT_W_DEF`, result field bit-position constants, and the FSM state enum `argmax_state_t`.
- No sub-module needed. The compare/update datapath and the FSM live in a single module.

## Test plan
- Full frame of 10 beats, logits {-5,3,7,2,7,-1,0,6,1,-8}, last on beat 10 → `result`=32'h8002_0007 one cycle after the last beat. Tie at index 4 ignored; `logit_ready` low for 1 cycle.
- All-negative frame, max -2 at index 9 → `result`=32'h8009_FFFE (sign extension verified).
- Short frame, last on beat 4, max 5 at index 1 → `result`=32'hC001_0005. Next good frame keeps [30]=1 until `clear`, after which `result`=32'h8xxx_xxxx with [30]=0.
- Long frame, 10 beats with no last and max at index 3 → force commit with error, `result`=32'hC003_xxxx. Beat 11 starts a new frame with idx=0.
- `clear` asserted in the commit cycle → done=1 retained. `clear` one cycle later → [31:30]=0 and the low 24 bits unchanged. Random `logit_valid` gaps give the same results as back-to-back beats.
- With `LOGIT_ARGMAX_SEQ_EN`, 65 frames → [29:24]=1 (wrap). Assert `reset_n` mid-frame → `result`=0, and the next full frame commits with seq=1.
